mux_rr_arb: RTL

MUX_RR_ARB -- requirements
Module: mux_rr_arb

---
 rtl/mux_rr_arb_pkg.sv | 19 +
 rtl/mux_rr_arb_rr_arbiter.sv | 40 ++++
 rtl/mux_rr_arb.sv | 106 ++++++++++
 3 files changed

// File: rtl/mux_rr_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mux_rr_arb_pkg
// Brief  : Shared mode and FSM state encodings for the mux/arbiter slice.
// Rev    : 1.0  initial release
// ============================================================================
package mux_rr_arb_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_rr_arb_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : First-request search upward from a start pointer, wrapping at the top.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [IDX_W-1:0]    i_ptr,
  output logic [CHANNELS-1:0] o_grant,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_any
);

  localparam logic [IDX_W:0] C_NCH = (IDX_W+1)'(CHANNELS);

  logic [IDX_W:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      w_cand = {1'b0, i_ptr} + (IDX_W+1)'(off);
      if (w_cand >= C_NCH) w_cand = w_cand - C_NCH;
      if (!o_any && i_req[w_cand[IDX_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[IDX_W-1:0];
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mux_rr_arb
// Brief  : N-to-1 registered mux, direct-select or round-robin, with a
//          one-entry output register and valid/ready handshakes.
// Rev    : 1.0  initial release
// ============================================================================
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 1,
  localparam int CHANNEL_BITS = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNEL_BITS-1:0]   sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHANNEL_BITS-1:0]   out_chan,
  input  logic                      out_ready
);

  localparam logic [CHANNEL_BITS:0]   C_NCH  = (CHANNEL_BITS+1)'(CHANNELS);
  localparam logic [CHANNEL_BITS-1:0] C_LAST = CHANNEL_BITS'(CHANNELS-1);

  state_t                  r_state;
  logic [WIDTH-1:0]        r_data;
  logic [CHANNEL_BITS-1:0] r_chan;
  logic [CHANNEL_BITS-1:0] r_rr_ptr;

  logic [CHANNELS-1:0]     w_req;
  logic [CHANNELS-1:0]     w_grant;
  logic [CHANNEL_BITS-1:0] w_ptr;
  logic [CHANNEL_BITS-1:0] w_idx;
  logic [CHANNEL_BITS-1:0] w_next_ptr;
  logic                    w_any;
  logic                    w_can_load;
  logic                    w_in_xfer;
  logic [WIDTH-1:0]        w_mux_data;

  // Direct-select mode reuses the arbiter with a single masked request.
  generate
    if (MODE == MODE_SEL) begin : g_sel
      logic w_sel_ok;
      logic w_unused_ptr;
      assign w_sel_ok     = ({1'b0, sel} < C_NCH);
      assign w_req        = w_sel_ok ? (in_valid & (CHANNELS'(1) << sel)) : '0;
      assign w_ptr        = w_sel_ok ? sel : '0;
      assign w_unused_ptr = ^r_rr_ptr;
    end else begin : g_rr
      logic w_unused_sel;
      assign w_req        = in_valid;
      assign w_ptr        = r_rr_ptr;
      assign w_unused_sel = ^sel;
    end
  endgenerate

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (CHANNEL_BITS)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_can_load = (r_state == ST_EMPTY) || out_ready;
  assign w_in_xfer  = rst_n && w_can_load && w_any;
  assign in_ready   = (rst_n && w_can_load) ? w_grant : '0;
  assign w_mux_data = in_data[w_idx*WIDTH +: WIDTH];
  assign w_next_ptr = (w_idx == C_LAST) ? '0 : w_idx + CHANNEL_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_data   <= '0;
      r_chan   <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_in_xfer) begin
        r_data   <= w_mux_data;
        r_chan   <= w_idx;
        r_rr_ptr <= w_next_ptr;
      end
      case (r_state)
        ST_EMPTY: if (w_in_xfer) r_state <= ST_FULL;
        ST_FULL:  if (out_ready && !w_in_xfer) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule
`default_nettype wire
